// File: rtl/mlp_acc_pkg.sv
// ============================================================================
// Package : mlp_acc_pkg
// Brief   : Shared FSM state type, saturation bounds and accumulator sizing
//           for the MLP-Mixer dot-product layers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mlp_acc_pkg;

  localparam int MLP_ACC_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_REQ   = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_e;

  function automatic int sat_max(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int bits);
    return -(1 << (bits - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/requant_sat.sv
// ============================================================================
// Module : requant_sat
// Brief  : Round-half-up arithmetic right shift and saturation of a wide
//          accumulator to a signed BITS-wide value. Macro ACC_RELU_EN clamps
//          negative results to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module requant_sat
  import mlp_acc_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int ACC_BITS = MLP_ACC_BITS,
  parameter int SHIFT    = 7
) (
  input  logic signed [ACC_BITS-1:0] acc,
  output logic signed [BITS-1:0]     q
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int c_w = ACC_BITS + 1;
  localparam logic signed [c_w-1:0] c_round = c_w'(2 ** (SHIFT - 1));
  localparam logic signed [c_w-1:0] c_max   = c_w'(sat_max(BITS));
  localparam logic signed [c_w-1:0] c_min   = c_w'(sat_min(BITS));

  logic signed [c_w-1:0] w_sum;
  logic signed [c_w-1:0] w_r;

  always_comb begin
    w_sum = {acc[ACC_BITS-1], acc} + c_round;
    w_r   = w_sum >>> SHIFT;
  end

  always_comb begin
    if (w_r > c_max) begin
      q = c_max[BITS-1:0];
    end else if (w_r < c_min) begin
      q = c_min[BITS-1:0];
    end else begin
      q = w_r[BITS-1:0];
    end
`ifdef ACC_RELU_EN
    if (w_r[c_w-1]) begin
      q = '0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ============================================================================
// Module : mac_accumulator
// Brief  : Accumulates VEC_LEN signed products plus bias, then requantises to
//          a BITS-wide activation behind a valid/ready output. Optional
//          macro ACC_RELU_EN fuses a ReLU into the requantiser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_accumulator
  import mlp_acc_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int ACC_BITS = MLP_ACC_BITS,
  parameter int VEC_LEN  = 16,
  parameter int SHIFT    = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [ACC_BITS-1:0] bias,
  input  logic                       in_valid,
  input  logic signed [2*BITS-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITS-1:0]     out_data,
  output logic                       busy,
  output logic                       drop_err
);

  localparam int c_cnt_w = $clog2(VEC_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(VEC_LEN - 1);

  acc_state_e                 r_state;
  acc_state_e                 w_next;
  logic signed [ACC_BITS-1:0] r_acc;
  logic signed [ACC_BITS-1:0] w_prod_ext;
  logic [c_cnt_w-1:0]         r_cnt;
  logic                       w_load;
  logic                       w_add;
  logic                       w_drop;
  logic signed [BITS-1:0]     w_q;

  assign w_prod_ext = {{(ACC_BITS - 2*BITS){in_data[2*BITS-1]}}, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_ACCUM;
      ST_ACCUM: if (in_valid && (r_cnt == c_last)) w_next = ST_REQ;
      ST_REQ:   w_next = ST_OUT;
      ST_OUT:   if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != ST_IDLE);
    w_load = (r_state == ST_IDLE) && start;
    w_add  = (r_state == ST_ACCUM) && in_valid;
    w_drop = in_valid && (((r_state == ST_IDLE) && !start) ||
                          (r_state == ST_REQ) || (r_state == ST_OUT));
  end

  // Bias load can absorb the first product in the same cycle as start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc <= in_valid ? (bias + w_prod_ext) : bias;
        r_cnt <= {{(c_cnt_w - 1){1'b0}}, in_valid};
      end else if (w_add) begin
        r_acc <= r_acc + w_prod_ext;
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (r_state == ST_REQ) begin
        out_data  <= w_q;
        out_valid <= 1'b1;
      end else if ((r_state == ST_OUT) && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_drop) begin
        drop_err <= 1'b1;
      end
    end
  end

  requant_sat #(
    .BITS     (BITS),
    .ACC_BITS (ACC_BITS),
    .SHIFT    (SHIFT)
  ) u_requant (
    .acc (r_acc),
    .q   (w_q)
  );

endmodule

`default_nettype wire
